// File: rtl/spike_pkg.sv
// Shared sizes and FSM state encoding for the spike encoder.
// The arbitrator imports NUM_SPIKES from here as well.
package spike_pkg;

   localparam int unsigned SAMPLE_W   = 12;
   localparam int unsigned NUM_CH     = 3;
   localparam int unsigned NUM_SPIKES = 2 * NUM_CH;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ENCODE = 2'd1,
      HALT   = 2'd2
   } state_t;

endpackage

// File: rtl/spike_enc_channel.sv
// One level-crossing channel: reference tracker, per-sample step cap, up/down decision.
// Optional refractory blocking is compiled in with SPIKE_ENC_REFRACT_EN.
module spike_enc_channel
   import spike_pkg::*;
#(
   parameter int unsigned TH        = 16,
   parameter int unsigned MAX_STEPS = 8,
   parameter int unsigned REFRACT   = 1
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                start,
   input  logic                enable,
   input  logic [SAMPLE_W-1:0] sample,
   output logic                up_c,
   output logic                down_c,
   output logic                blocked_c
);

   localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);
   localparam logic signed [SAMPLE_W:0] TH_S = (SAMPLE_W + 1)'(TH);

   logic [SAMPLE_W-1:0]      ref_q;
   logic [STEP_W-1:0]        steps_q;
   logic signed [SAMPLE_W:0] diff_c;
   logic                     capped_c;

   // Reference never passes the sample, so the 13-bit difference cannot overflow.
   assign diff_c   = $signed({sample[SAMPLE_W-1], sample}) - $signed({ref_q[SAMPLE_W-1], ref_q});
   assign capped_c = (steps_q == STEP_W'(MAX_STEPS));
   assign up_c     = enable && !capped_c && !blocked_c && (diff_c >= TH_S);
   assign down_c   = enable && !capped_c && !blocked_c && (diff_c <= -TH_S);

   always_ff @(posedge clk) begin
      if (resetn) begin
         ref_q   <= '0;
         steps_q <= '0;
      end else if (start) begin
         steps_q <= '0;
      end else if (up_c) begin
         ref_q   <= ref_q + SAMPLE_W'(TH);
         steps_q <= steps_q + STEP_W'(1);
      end else if (down_c) begin
         ref_q   <= ref_q - SAMPLE_W'(TH);
         steps_q <= steps_q + STEP_W'(1);
      end
   end

`ifdef SPIKE_ENC_REFRACT_EN
   localparam int unsigned RF_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

   logic [RF_W-1:0] rf_q;

   assign blocked_c = (rf_q != '0);

   // Reload on every spike, then count down; a blocked channel holds the FSM in ENCODE.
   always_ff @(posedge clk) begin
      if (resetn) begin
         rf_q <= '0;
      end else if (up_c || down_c) begin
         rf_q <= RF_W'(REFRACT);
      end else if (rf_q != '0) begin
         rf_q <= rf_q - RF_W'(1);
      end
   end
`else
   assign blocked_c = 1'b0;
`endif

endmodule

// File: rtl/spike_encoder.sv
// Three-channel level-crossing ECG spike encoder with IDLE/ENCODE/HALT control.
// Define SPIKE_ENC_REFRACT_EN to add per-channel refractory blocking.
module spike_encoder
   import spike_pkg::*;
#(
   parameter int unsigned TH0       = 16,
   parameter int unsigned TH1       = 64,
   parameter int unsigned TH2       = 256,
   parameter int unsigned MAX_STEPS = 8,
   parameter int unsigned REFRACT   = 1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [SAMPLE_W-1:0]   sample_in,
   input  logic                  sample_valid,
   output logic                  sample_ready,
   input  logic                  stop_in,
   output logic [NUM_SPIKES-1:0] spikes_out,
   output logic                  busy
);

   state_t                  state_q, state_d;
   logic [SAMPLE_W-1:0]     sample_q;
   logic [NUM_SPIKES-1:0]   spikes_q, spikes_d;
   logic                    ready_q, busy_q;
   logic                    accept_c, encode_c;
   logic [NUM_CH-1:0]       up_c, down_c, blocked_c;

   // stop_in wins over a simultaneous acceptance and freezes the channels.
   assign accept_c = (state_q == IDLE) && sample_valid && !stop_in;
   assign encode_c = (state_q == ENCODE) && !stop_in;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam int unsigned TH = (i == 0) ? TH0 : (i == 1) ? TH1 : TH2;

      spike_enc_channel #(
         .TH        (TH),
         .MAX_STEPS (MAX_STEPS),
         .REFRACT   (REFRACT)
      ) u_ch (
         .clk       (clk),
         .resetn    (resetn),
         .start     (accept_c),
         .enable    (encode_c),
         .sample    (sample_q),
         .up_c      (up_c[i]),
         .down_c    (down_c[i]),
         .blocked_c (blocked_c[i])
      );
   end

   always_comb begin
      state_d  = state_q;
      spikes_d = '0;
      case (state_q)
         IDLE: begin
            if (stop_in) begin
               state_d = HALT;
            end else if (sample_valid) begin
               state_d = ENCODE;
            end
         end
         ENCODE: begin
            if (stop_in) begin
               state_d = HALT;
            end else begin
               for (int i = 0; i < int'(NUM_CH); i++) begin
                  spikes_d[2*i]   = up_c[i];
                  spikes_d[2*i+1] = down_c[i];
               end
               if (!(|up_c) && !(|down_c) && !(|blocked_c)) begin
                  state_d = IDLE;
               end
            end
         end
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         state_q  <= IDLE;
         sample_q <= '0;
         spikes_q <= '0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         spikes_q <= spikes_d;
         ready_q  <= (state_d == IDLE);
         busy_q   <= (state_d == ENCODE);
         if (accept_c) begin
            sample_q <= sample_in;
         end
      end
   end

   assign spikes_out   = spikes_q;
   assign sample_ready = ready_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_spike_encoder.sv
// Bench for spike_encoder: directed table, random samples against a per-sample
// arithmetic model, and hand sequences for stop, reset and refractory behaviour.
module tb_spike_encoder;

   localparam int MAXS = 8;
`ifdef SPIKE_ENC_REFRACT_EN
   localparam int RF = 1;
`else
   localparam int RF = 0;
`endif

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic [11:0] sample_in = '0;
   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic        stop_in = 1'b0;
   logic [5:0]  spikes_out;
   logic        busy;

   spike_encoder u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .stop_in      (stop_in),
      .spikes_out   (spikes_out),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int         vec_cnt = 0;
   int         err_cnt = 0;
   int         th_m[3] = '{16, 64, 256};
   int         ref_m[3] = '{0, 0, 0};
   logic [5:0] exp_q[$];
   int         exp_lat;
   logic [5:0] act_q[$];
   logic       act_busy[$];
   int         act_lat;

   typedef struct {
      bit         rst;
      int         sample;
      int         lat;
      logic [5:0] first;
      int         total;
   } vec_t;

   vec_t tbl[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Each channel fires floor(|diff|/TH) times (capped), one spike every RF+1 cycles.
   task automatic predict(input int s);
      int         n[3];
      int         dir[3];
      int         lat;
      logic [5:0] w;
      lat = 1;
      for (int i = 0; i < 3; i++) begin
         int d;
         d      = s - ref_m[i];
         dir[i] = (d < 0) ? -1 : 1;
         n[i]   = ((d < 0) ? -d : d) / th_m[i];
         if (n[i] > MAXS) n[i] = MAXS;
         if (n[i] > 0 && n[i] * (RF + 1) + 1 > lat) lat = n[i] * (RF + 1) + 1;
         ref_m[i] += dir[i] * n[i] * th_m[i];
      end
      exp_q.delete();
      for (int k = 1; k < lat; k++) begin
         w = '0;
         for (int i = 0; i < 3; i++) begin
            if (n[i] > 0 && (k - 1) % (RF + 1) == 0 && (k - 1) / (RF + 1) < n[i])
               w[2*i + ((dir[i] < 0) ? 1 : 0)] = 1'b1;
         end
         exp_q.push_back(w);
      end
      exp_lat = lat;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("rst_spikes", 32'(spikes_out), 32'd0);
      check("rst_ready", 32'(sample_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      resetn = 1'b0;
      ref_m = '{0, 0, 0};
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 64; c++) begin
         if (sample_ready) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
      check("wait_ready", 32'(sample_ready), 32'd1);
   endtask

   task automatic apply_sample(input int s, input string tag);
      bit ok;
      wait_ready(ok);
      if (!ok) return;
      predict(s);
      sample_in    = 12'(s);
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      act_q.delete();
      act_busy.delete();
      act_lat = 0;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         act_q.push_back(spikes_out);
         act_busy.push_back(busy);
         if (sample_ready) begin
            act_lat = k;
            break;
         end
      end
      check({tag, "_lat"}, 32'(act_lat), 32'(exp_lat));
      for (int k = 1; k <= int'(act_q.size()) && k <= exp_lat; k++) begin
         check({tag, "_spk"}, 32'(act_q[k-1]), 32'((k < exp_lat) ? exp_q[k-1] : 6'd0));
         check({tag, "_busy"}, 32'(act_busy[k-1]), 32'(k < exp_lat));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         s, c, sgn, off, total;
      logic [5:0] first;
      int         rf_pat[5] = '{1, 0, 1, 0, 0};

      tbl[0] = '{1'b1,    40, 3, 6'b000001,  2};
      tbl[1] = '{1'b1,  -300, 9, 6'b101010, 13};
      tbl[2] = '{1'b0,     0, 9, 6'b010101, 13};
      tbl[3] = '{1'b0,    15, 1, 6'b000000,  0};
      tbl[4] = '{1'b0,    16, 2, 6'b000001,  1};
      tbl[5] = '{1'b0,     0, 2, 6'b000010,  1};
      tbl[6] = '{1'b0,  2047, 9, 6'b010101, 23};
      tbl[7] = '{1'b0, -2048, 9, 6'b101010, 24};
      tbl[8] = '{1'b0,    63, 4, 6'b010001,  4};

      do_reset();

      // Directed table; refs carry over between rows unless rst is set.
      for (int i = 0; i < 9; i++) begin
         if (tbl[i].rst) do_reset();
         apply_sample(tbl[i].sample, "tbl");
         first = (act_q.size() > 0) ? act_q[0] : 6'bxxxxxx;
         total = 0;
         foreach (act_q[k]) total += $countones(act_q[k]);
`ifndef SPIKE_ENC_REFRACT_EN
         check("tbl_lat_hand", 32'(act_lat), 32'(tbl[i].lat));
`endif
         check("tbl_first", 32'(first), 32'(tbl[i].first));
         check("tbl_total", 32'(total), 32'(tbl[i].total));
      end

      // Random samples, biased toward threshold boundaries around the current refs.
      for (int r = 0; r < 40; r++) begin
         if ($urandom_range(0, 9) == 0) do_reset();
         case ($urandom_range(0, 2))
            0: s = int'($urandom_range(0, 4095)) - 2048;
            default: begin
               c   = int'($urandom_range(0, 2));
               sgn = ($urandom_range(0, 1) == 0) ? -1 : 1;
               off = int'($urandom_range(0, 2)) - 1;
               s   = ref_m[c] + sgn * (th_m[c] + off);
            end
         endcase
         if (s > 2047) s = 2047;
         if (s < -2048) s = -2048;
         apply_sample(s, "rnd");
      end

      // stop_in on the second ENCODE cycle: HALT, and only reset recovers.
      do_reset();
      predict(-300);
      sample_in    = 12'(-300);
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
      check("stop_pre_spk", 32'(spikes_out), 32'(exp_q[0]));
      stop_in = 1'b1;
      @(negedge clk);
      stop_in = 1'b0;
      check("stop_spk", 32'(spikes_out), 32'd0);
      check("stop_ready", 32'(sample_ready), 32'd0);
      check("stop_busy", 32'(busy), 32'd0);
      sample_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("halt_spk", 32'(spikes_out), 32'd0);
         check("halt_ready", 32'(sample_ready), 32'd0);
         check("halt_busy", 32'(busy), 32'd0);
      end
      sample_valid = 1'b0;
      do_reset();

      // sample_valid together with stop_in in IDLE: no acceptance, straight to HALT.
      apply_sample(40, "pre_stop");
      sample_in    = 12'd1000;
      sample_valid = 1'b1;
      stop_in      = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      stop_in      = 1'b0;
      check("vs_ready", 32'(sample_ready), 32'd0);
      check("vs_busy", 32'(busy), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("vs_spk", 32'(spikes_out), 32'd0);
      end
      do_reset();

      // Reset in the middle of ENCODE, then a fresh encode from zero refs.
      predict(-300);
      sample_in    = 12'(-300);
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_spk", 32'(spikes_out), 32'(exp_q[1]));
      do_reset();
      apply_sample(40, "post_rst");

`ifdef SPIKE_ENC_REFRACT_EN
      do_reset();
      apply_sample(40, "rf");
      check("rf_lat_hand", 32'(act_lat), 32'd5);
      for (int k = 0; k < 5 && k < int'(act_q.size()); k++)
         check("rf_bit0", 32'(act_q[k][0]), 32'(rf_pat[k]));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- TH0, 16: channel 0 level-crossing threshold (positive).
- TH1, 64: channel 1 threshold.
- TH2, 256: channel 2 threshold.
- MAX_STEPS, 8: maximum spikes per channel per sample.
- REFRACT, 1: refractory cycles per channel (used only with the macro).
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: the single clock; rising-edge.
- resetn, in, 1: synchronous, active-high reset.
- sample_in, in, 12: signed ECG sample.
- sample_valid, in, 1: sample_in valid.
- sample_ready, out, 1: encoder can accept a sample.
- stop_in, in, 1: halt request from the arbitrator's end_process.
- spikes_out, out, 6: network input spikes; bit 2i = channel i up, bit 2i+1 = channel i down.
- busy, out, 1: high in ENCODE.

Function
REQ-003 A sample is accepted on an edge where sample_valid and sample_ready are both high.
REQ-004 States: IDLE, ENCODE and HALT; sample_ready = (state==IDLE).
REQ-005 IDLE -> ENCODE on acceptance; the sample is latched, and each channel's step count is cleared.
REQ-006 In each ENCODE cycle, each channel i computes diff = sample - ref_i (13-bit signed, no overflow) and applies one decision:
- diff >= THi: fire up; ref_i += THi.
- diff <= -THi: fire down; ref_i -= THi.
- Otherwise: converged.
REQ-007 A channel does not fire when its step count equals MAX_STEPS (capped); any residual difference is dropped.
REQ-008 Each decision is registered onto spikes_out at the next edge; every spike is a one-cycle pulse, and there is no combinational path to spikes_out.
REQ-009 ENCODE -> IDLE at the edge ending the first ENCODE cycle in which no channel fires and no channel is refractory; spikes_out is 0 after that edge.
REQ-010 ref_i never passes the sample, so no saturation logic exists; ref_i persists across samples (delta encoding).
REQ-011 stop_in high in IDLE or ENCODE: the next state is HALT and spikes_out is 0 after that edge.
REQ-012 stop_in has priority over a simultaneous acceptance; that sample is not taken.
REQ-013 HALT is left only by reset; while in HALT, spikes_out = 0 and sample_ready = 0.

Reset
REQ-014 resetn high at an edge sets the following, whatever the current state, including mid-ENCODE:
- state = IDLE, ref_i = 0, step counts = 0, refractory counters = 0.
- spikes_out = 0, busy = 0, sample_ready = 1.

Configuration
REQ-015 Macro SPIKE_ENC_REFRACT_EN defined: after a channel fires, it is blocked from firing for REFRACT cycles; it is not converged while blocked, and firing resumes afterward.
REQ-016 Macro absent: no refractory logic is compiled in, and a channel may fire on consecutive cycles.

Structure
REQ-017 Package spike_pkg holds SAMPLE_W=12, NUM_CH=3, NUM_SPIKES=6 and the state enum (IDLE/ENCODE/HALT); the arbitrator shares NUM_SPIKES.
REQ-018 Sub-module spike_enc_channel holds one channel's ref, step count, decision and optional refractory counter, and is instantiated NUM_CH times; the top holds the FSM.

Verification (default parameters)
REQ-019 Reset -> spikes_out=0, sample_ready=1, busy=0.
REQ-020 From ref=0, accept +40:
- spikes_out=6'b000001 for 2 cycles, then 0.
- ref0=32.
- sample_ready high 3 cycles after acceptance.
REQ-021 From ref=0, accept -300:
- spikes_out = 6'b101010 for 1 cycle, then 6'b001010 for 3 cycles, then 6'b000010 for 4 cycles.
- Final refs: ref0=-128 (capped), ref1=-256, ref2=-256.
- IDLE 9 cycles after acceptance.
REQ-022 stop_in pulsed on the 2nd ENCODE cycle of the -300 case -> spikes_out=0 thereafter; sample_ready stays 0 under further sample_valid until resetn.
REQ-023 sample_valid and stop_in together in IDLE -> HALT, sample not accepted, refs unchanged.
REQ-024 With SPIKE_ENC_REFRACT_EN and REFRACT=1, accept +40 -> bit0 pattern 1,0,1 then 0; IDLE 5 cycles after acceptance.
